// File: rtl/data_mem_responder.sv
// data_mem_responder
//   Word-addressed data memory for a CPU data port. Each request is captured,
//   held for WAIT_STATES extra cycles, performed on a single access edge, and
//   acknowledged by a one-cycle mem_ready pulse.
//
// Ports
//   clk           rising-edge clock
//   reset         asynchronous, active-low reset
//   mem_rd        read request
//   mem_wr        write request
//   ram_addr      12-bit word address
//   data_mem_in   32-bit write data
//   data_mem_out  32-bit read data (registered, held between reads)
//   mem_ready     one-cycle completion pulse (registered)
//   mem_err       error qualifier, only meaningful with mem_ready (registered)
//   xfer_count    16-bit count of successful accesses (registered, wraps)
module data_mem_responder #(
    parameter int WAIT_STATES = 1,
    parameter int DEPTH       = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_rd,
    input  logic        mem_wr,
    input  logic [11:0] ram_addr,
    input  logic [31:0] data_mem_in,
    output logic [31:0] data_mem_out,
    output logic        mem_ready,
    output logic        mem_err,
    output logic [15:0] xfer_count
);

    localparam int          AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [12:0] DEPTH_LIM = 13'(DEPTH);
    localparam logic [3:0]  WS_LOAD   = 4'(WAIT_STATES);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    // Storage has no reset: contents survive the reset pin.
    logic [31:0] mem_array [DEPTH];

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        rd_q, rd_d;
    logic        wr_q, wr_d;
    logic [11:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] dout_q, dout_d;
    logic        ready_q, ready_d;
    logic        err_q, err_d;
    logic [15:0] count_q, count_d;

    logic          mem_we;
    logic [AW-1:0] idx;
    logic          acc_err;

    assign idx     = addr_q[AW-1:0];
    // Both strobes set, or an address past the end of storage, is an error.
    assign acc_err = (rd_q & wr_q) | ({1'b0, addr_q} >= DEPTH_LIM);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        dout_d  = dout_q;
        ready_d = 1'b0;
        err_d   = 1'b0;
        count_d = count_q;
        mem_we  = 1'b0;

        case (state_q)
            // RESP behaves like IDLE for capture so back-to-back requests
            // complete on alternate cycles with no bubble.
            S_IDLE, S_RESP: begin
                state_d = S_IDLE;
                if (mem_rd | mem_wr) begin
                    rd_d    = mem_rd;
                    wr_d    = mem_wr;
                    addr_d  = ram_addr;
                    wdata_d = data_mem_in;
                    cnt_d   = WS_LOAD;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    // Access edge.
                    ready_d = 1'b1;
                    err_d   = acc_err;
                    state_d = S_RESP;
                    if (acc_err) begin
                        dout_d = 32'h0;
                    end else begin
                        count_d = count_q + 16'd1;
                        if (rd_q) dout_d = mem_array[idx];
                        else      mem_we = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= 12'h0;
            wdata_q <= 32'h0;
            dout_q  <= 32'h0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            count_q <= 16'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            dout_q  <= dout_d;
            ready_q <= ready_d;
            err_q   <= err_d;
            count_q <= count_d;
        end
    end

    // mem_we only asserts from WAIT, and reset forces IDLE asynchronously,
    // so an aborted write can never reach the array.
    always_ff @(posedge clk) begin
        if (mem_we) mem_array[idx] <= wdata_q;
    end

    assign data_mem_out = dout_q;
    assign mem_ready    = ready_q;
    assign mem_err      = err_q;
    assign xfer_count   = count_q;

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;

    localparam int WS    = 1;
    localparam int DEPTH = 1024;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    always #5 clk = ~clk;

    // main instance: WAIT_STATES=1, DEPTH=1024
    logic        mem_rd = 0, mem_wr = 0;
    logic [11:0] ram_addr = 0;
    logic [31:0] data_mem_in = 0;
    logic [31:0] data_mem_out;
    logic        mem_ready, mem_err;
    logic [15:0] xfer_count;

    data_mem_responder #(.WAIT_STATES(WS), .DEPTH(DEPTH)) u_dut (
        .clk(clk), .reset(reset), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .ram_addr(ram_addr), .data_mem_in(data_mem_in),
        .data_mem_out(data_mem_out), .mem_ready(mem_ready),
        .mem_err(mem_err), .xfer_count(xfer_count));

    // zero-wait instance for back-to-back streaming
    logic        z_rd = 0, z_wr = 0;
    logic [11:0] z_addr = 0;
    logic [31:0] z_din = 0;
    logic [31:0] z_dout;
    logic        z_ready, z_err;
    logic [15:0] z_count;

    data_mem_responder #(.WAIT_STATES(0), .DEPTH(16)) u_z (
        .clk(clk), .reset(reset), .mem_rd(z_rd), .mem_wr(z_wr),
        .ram_addr(z_addr), .data_mem_in(z_din),
        .data_mem_out(z_dout), .mem_ready(z_ready),
        .mem_err(z_err), .xfer_count(z_count));

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // reference model: memory contents, last returned data, success count
    logic [31:0] m_mem [int];
    logic [31:0] m_out = 0;
    int          m_cnt = 0;
    int          written [$];

    // Issue one transaction, check latency and completion against the model.
    task automatic txn(input logic rd, input logic wr, input int addr, input logic [31:0] din);
        bit err, done;
        int lat;
        @(negedge clk);
        mem_rd = rd; mem_wr = wr; ram_addr = 12'(addr); data_mem_in = din;
        @(posedge clk); #1;
        // scramble inputs while the transaction is in flight
        ram_addr = 12'($urandom); data_mem_in = $urandom;
        mem_rd = 1'($urandom); mem_wr = 1'($urandom);
        // model
        err = (rd && wr) || (addr >= DEPTH);
        if (err) m_out = 0;
        else if (rd) m_out = m_mem[addr];
        else begin
            m_mem[addr] = din;
            written.push_back(addr);
        end
        if (!err) m_cnt = (m_cnt + 1) % 65536;
        done = 0; lat = 0;
        for (int i = 1; i <= 8 && !done; i++) begin
            @(posedge clk); #1;
            mem_rd = 0; mem_wr = 0;
            if (mem_ready) begin done = 1; lat = i; end
            else chk("err_without_ready", 32'(mem_err), 0);
        end
        if (!done) chk("ready_timeout", 0, 1);
        else begin
            chk("latency", lat, WS + 1);
            chk("mem_err", 32'(mem_err), 32'(err));
            chk("data_out", data_mem_out, m_out);
            chk("xfer_count", 32'(xfer_count), 32'(m_cnt));
        end
    endtask

    initial begin
        // reset state, with clock running
        repeat (2) @(posedge clk);
        #1;
        chk("rst_dout", data_mem_out, 0);
        chk("rst_ready", 32'(mem_ready), 0);
        chk("rst_err", 32'(mem_err), 0);
        chk("rst_count", 32'(xfer_count), 0);
        @(negedge clk); reset = 1;

        // basic write then read
        txn(0, 1, 'h010, 32'hDEADBEEF);
        txn(1, 0, 'h010, 32'h0);
        chk("rd_deadbeef", data_mem_out, 32'hDEADBEEF);
        chk("count_2", 32'(xfer_count), 2);

        // illegal: both strobes
        txn(0, 1, 'h020, 32'hCAFE0001);
        txn(1, 1, 'h020, 32'h0BAD0BAD);
        chk("illegal_dout", data_mem_out, 0);
        txn(1, 0, 'h020, 32'h0);
        chk("illegal_mem_kept", data_mem_out, 32'hCAFE0001);

        // out of range
        txn(0, 1, 'h400, 32'h11111111);
        txn(1, 0, 'h400, 32'h0);
        txn(1, 0, 'hFFF, 32'h0);

        // randomized mix
        for (int t = 0; t < 80; t++) begin
            int k;
            k = $urandom_range(0, 9);
            if (k == 0) txn(1, 1, $urandom_range(0, 63), $urandom);
            else if (k == 1) txn(1'($urandom), 1'($urandom) | 1'b1, $urandom_range(DEPTH, 4095), $urandom);
            else if (k < 6 || written.size() == 0) txn(0, 1, $urandom_range(0, 63), $urandom);
            else txn(1, 0, written[$urandom_range(0, written.size() - 1)], 0);
        end

        // reset mid-transaction aborts a pending write
        txn(0, 1, 'h005, 32'h55AA55AA);
        txn(1, 0, 'h005, 32'h0);
        @(negedge clk);
        mem_wr = 1; ram_addr = 12'h005; data_mem_in = 32'h12345678;
        @(posedge clk); #1;
        mem_wr = 0;
        #2 reset = 0;
        #1;
        chk("abort_dout", data_mem_out, 0);
        chk("abort_ready", 32'(mem_ready), 0);
        chk("abort_err", 32'(mem_err), 0);
        chk("abort_count", 32'(xfer_count), 0);
        m_out = 0; m_cnt = 0;
        repeat (2) @(posedge clk);
        #1 chk("abort_hold_count", 32'(xfer_count), 0);
        @(negedge clk); reset = 1;
        txn(1, 0, 'h005, 32'h0);
        chk("abort_old_data", data_mem_out, 32'h55AA55AA);

        // zero-wait streaming: writes then reads with strobes held high
        begin
            logic [7:0]  exp_rdy;
            logic [31:0] exp_d [8];
            exp_rdy = 8'b1010_1010; // index = edge number, bit set on access edges
            exp_d[5] = 32'hA0A0A0A0; exp_d[7] = 32'hB1B1B1B1;
            @(negedge clk);
            z_wr = 1; z_addr = 0; z_din = 32'hA0A0A0A0;
            for (int e = 0; e < 8; e++) begin
                @(posedge clk); #1;
                chk($sformatf("z_ready_e%0d", e), 32'(z_ready), 32'(exp_rdy[e]));
                chk($sformatf("z_err_e%0d", e), 32'(z_err), 0);
                if (e == 5 || e == 7) chk($sformatf("z_data_e%0d", e), z_dout, exp_d[e]);
                @(negedge clk);
                case (e)
                    0: begin z_addr = 1; z_din = 32'hB1B1B1B1; end
                    2: begin z_wr = 0; z_rd = 1; z_addr = 0; end
                    4: z_addr = 1;
                    6: z_rd = 0;
                    default: ;
                endcase
            end
            chk("z_count", 32'(z_count), 4);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout got=%0d exp=0", 1);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 The block SHALL have parameter WAIT_STATES, default 1 (range 0..15), giving the number of extra wait cycles inserted before each access.
REQ-002 The block SHALL have parameter DEPTH, default 1024 (range 1..4096), giving the number of 32-bit words stored.
REQ-003 clk  input  1  sole clock; all state changes on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 mem_rd  input  1  read request from the CPU data port.
REQ-006 mem_wr  input  1  write request from the CPU data port.
REQ-007 ram_addr  input  12  word address of the request.
REQ-008 data_mem_in  input  32  write data from the CPU.
REQ-009 data_mem_out  output  32  read data returned to the CPU; registered.
REQ-010 mem_ready  output  1  one-cycle completion pulse; registered.
REQ-011 mem_err  output  1  error qualifier, valid only while mem_ready=1; registered.
REQ-012 xfer_count  output  16  count of successful accesses; registered.

Function
REQ-013 Storage SHALL be a DEPTH x 32 array with no reset of its contents.
REQ-014 The FSM SHALL have states IDLE, WAIT and RESP, plus a 4-bit wait counter.
REQ-015 IDLE: if mem_rd or mem_wr is 1 at an edge, the block SHALL capture mem_rd, mem_wr, ram_addr and data_mem_in, load the counter with WAIT_STATES, and go to WAIT. Otherwise it SHALL stay in IDLE.
REQ-016 WAIT: if the counter is nonzero, the block SHALL decrement it and stay in WAIT. If it is zero, the block SHALL perform the captured access on that edge and go to RESP.
REQ-017 RESP: mem_ready SHALL be 1 for exactly this one cycle, then the FSM SHALL return to IDLE. A new request SHALL be capturable on the edge that leaves RESP.
REQ-018 Latency: mem_ready SHALL rise WAIT_STATES+1 edges after the capture edge.
REQ-019 Request inputs SHALL be ignored in WAIT and RESP. Changes to them after the capture edge SHALL have no effect on the transaction in progress.
REQ-020 Read access: data_mem_out SHALL load mem[addr] on the access edge and hold that value until the next read or error completes.
REQ-021 Write access: mem[addr] SHALL be updated with the captured data on the access edge, and data_mem_out SHALL be unchanged.
REQ-022 Both mem_rd and mem_wr at capture SHALL be illegal: no array access, data_mem_out set to 0, mem_err=1 in RESP.
REQ-023 A captured address >= DEPTH SHALL be an error: a write is dropped, a read returns data_mem_out=0, and mem_err=1 in RESP.
REQ-024 mem_err SHALL be 0 whenever mem_ready is 0.
REQ-025 xfer_count SHALL increment by 1 on each non-error access edge and wrap from 16'hFFFF to 16'h0000. Error transactions SHALL NOT count.
REQ-026 A read immediately following a write to the same address SHALL return the newly written data.

Reset
REQ-027 While reset=0, the FSM SHALL be in IDLE, and the counter, data_mem_out, mem_ready, mem_err and xfer_count SHALL all be 0, independent of clk.
REQ-028 Reset asserted mid-transaction (WAIT or RESP) SHALL abort it immediately; a pending write not yet at its access edge SHALL NOT modify the array.
REQ-029 Array contents SHALL be preserved across reset.
REQ-030 After reset deasserts, the first rising edge SHALL be able to capture a request.

Verification
REQ-031 WAIT_STATES=1, DEPTH=1024: write 32'hDEADBEEF to 12'h010, then read 12'h010 -> each mem_ready arrives 2 edges after capture, read data_mem_out=32'hDEADBEEF, mem_err=0, xfer_count=2.
REQ-032 WAIT_STATES=0: back-to-back reads of 12'h000 and 12'h001 with mem_rd held high -> mem_ready pulses on alternate cycles, one cycle after each capture; no request is lost.
REQ-033 mem_rd=mem_wr=1 at 12'h020 -> mem_ready=1 with mem_err=1, data_mem_out=0, mem[12'h020] unchanged, xfer_count unchanged.
REQ-034 DEPTH=1024, write to 12'h400 then read 12'h400 -> both complete with mem_err=1, read data=0, xfer_count unchanged.
REQ-035 WAIT_STATES=3: capture a write of 32'h12345678 to 12'h005, assert reset 2 cycles later, release, then read 12'h005 -> returns the old contents; all outputs were 0 during reset.
REQ-036 Preload xfer_count to 16'hFFFF via 65535 good accesses, then one more good access -> xfer_count=16'h0000.
